alu_sequencer: RTL and testbench

- Hardwired control unit for the bus-based datapath.
- Runs the fetch cycle (T0–T2), then decodes the IR and drives the one-hot register out/in strobes and ALU controls for register-register and unary ALU instructions (T3–T5).
- Replaces the hand-written per-instruction control sequences used in the datapath benches. Sits beside the datapath and connects to its control inputs.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/reg_select_decoder.sv | 16 +
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, state codes and IR field positions.
// Optional MULDIV_EN adds the MD5/MD6 multiply/divide write-back states.
package cpu_pkg;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHRA = 5'b01000;
    localparam logic [4:0] OPC_SHL  = 5'b01001;
    localparam logic [4:0] OPC_ROR  = 5'b01010;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH0  = 4'd1,
        S_FETCH1  = 4'd2,
        S_FETCH2  = 4'd3,
        S_DECODE  = 4'd4,
        S_EXEC3   = 4'd5,
        S_EXEC4   = 4'd6,
        S_EXEC5   = 4'd7,
        S_UEXEC3  = 4'd8,
        S_HALT    = 4'd9,
        S_ILLEGAL = 4'd10
`ifdef MULDIV_EN
        ,
        S_MD5     = 4'd11,
        S_MD6     = 4'd12
`endif
    } state_t;

    function automatic logic is_binary(input logic [4:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
                           OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL};
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        return opc inside {OPC_NEG, OPC_NOT};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        return opc inside {OPC_MUL, OPC_DIV};
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field decoder: a 4-bit field plus enable becomes a one-hot strobe vector.
// Fields that index past NUM_REGS drive no strobe.
module reg_select_decoder #(
    parameter int NUM_REGS = 16,
    parameter int FIELD_W  = 4
) (
    input  logic [FIELD_W-1:0]  field,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign onehot[i] = en && (int'(field) == i);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired Moore control unit: fetch, decode, and register/ALU strobes for ALU instructions.
// Define MULDIV_EN to add mul/div sequencing and the LOin/HIin outputs.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic                Mem_ready,
    input  logic [31:0]         IR_data,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
`ifdef MULDIV_EN
    output logic                LOin,
    output logic                HIin,
`endif
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OP_W-1:0]     operation,
    output logic                Halted,
    output logic                Illegal
);

    state_t     state_q, state_d;
    logic       pc_done_q, pc_done_d;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic [3:0] rout_fld, rin_fld;
    logic       rout_en, rin_en;
    logic       md;
    logic       unused_ir;

    assign opc       = IR_data[IR_OPC_HI:IR_OPC_LO];
    assign ra        = IR_data[IR_RA_HI:IR_RA_LO];
    assign rb        = IR_data[IR_RB_HI:IR_RB_LO];
    assign rc        = IR_data[IR_RC_HI:IR_RC_LO];
    assign unused_ir = ^IR_data[IR_RC_LO-1:0];

`ifdef MULDIV_EN
    assign md = is_muldiv(opc);
`else
    assign md = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_done_q <= pc_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        // PC is loaded only on the first FETCH1 cycle, however long memory stalls.
        pc_done_d = (state_q == S_FETCH1);
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        ZHighout  = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Halted    = 1'b0;
        Illegal   = 1'b0;
        operation = '0;
        rout_en   = 1'b0;
        rout_fld  = rb;
        rin_en    = 1'b0;
        rin_fld   = ra;
`ifdef MULDIV_EN
        LOin      = 1'b0;
        HIin      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH0;
            end
            S_FETCH0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                Zlowout = 1'b1;
                PCin    = !pc_done_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (Mem_ready) state_d = S_FETCH2;
            end
            S_FETCH2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_binary(opc) || md) state_d = S_EXEC3;
                else if (is_unary(opc))   state_d = S_UEXEC3;
                else if (opc == OPC_NOP)  state_d = S_IDLE;
                else if (opc == OPC_HALT) state_d = S_HALT;
                else                      state_d = S_ILLEGAL;
            end
            S_EXEC3: begin
                rout_en  = 1'b1;
                rout_fld = md ? ra : rb;
                Yin      = 1'b1;
                state_d  = S_EXEC4;
            end
            S_EXEC4: begin
                rout_en   = 1'b1;
                rout_fld  = md ? rb : rc;
                Zin       = 1'b1;
                operation = OP_W'(opc);
`ifdef MULDIV_EN
                state_d   = md ? S_MD5 : S_EXEC5;
`else
                state_d   = S_EXEC5;
`endif
            end
            S_UEXEC3: begin
                rout_en   = 1'b1;
                rout_fld  = rb;
                Zin       = 1'b1;
                operation = OP_W'(opc);
                state_d   = S_EXEC5;
            end
            S_EXEC5: begin
                Zlowout = 1'b1;
                rin_en  = 1'b1;
                rin_fld = ra;
                state_d = S_IDLE;
            end
`ifdef MULDIV_EN
            S_MD5: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
                state_d = S_MD6;
            end
            S_MD6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            S_HALT: begin
                Halted = 1'b1;
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(4)) u_rout_dec (
        .field  (rout_fld),
        .en     (rout_en),
        .onehot (Rout)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(4)) u_rin_dec (
        .field  (rin_fld),
        .en     (rin_en),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: the driver pushes a per-cycle expected trace built from
// the instruction timeline; a negedge monitor compares every cycle's outputs against it.
module tb_alu_sequencer;

    localparam int NR = 16;

    localparam logic [15:0] PCO = 16'h0001, MAR = 16'h0002, INC = 16'h0004, PCI = 16'h0008;
    localparam logic [15:0] ZI  = 16'h0010, ZL  = 16'h0020, ZH  = 16'h0040, RD  = 16'h0080;
    localparam logic [15:0] MDI = 16'h0100, MDO = 16'h0200, IRI = 16'h0400, YI  = 16'h0800;
    localparam logic [15:0] HLT = 16'h1000, ILL = 16'h2000, LOI = 16'h4000, HII = 16'h8000;

    localparam logic [4:0] T_AND = 5'b00101, T_SHL = 5'b01001, T_NEG = 5'b10001;
    localparam logic [4:0] T_MUL = 5'b01111, T_DIV = 5'b10000;
    localparam logic [4:0] T_NOP = 5'b11010, T_HALT = 5'b11011;

    typedef struct packed {
        logic [15:0]   strb;
        logic [NR-1:0] rout;
        logic [NR-1:0] rin;
        logic [4:0]    op;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset, Run, Mem_ready;
    logic [31:0]   IR_data;
    logic          PCout, MARin, IncPC, PCin, Zin, Zlowout, ZHighout, Read;
    logic          MDRin, MDRout, IRin, Yin, Halted, Illegal, LOin, HIin;
    logic [NR-1:0] Rout, Rin;
    logic [4:0]    operation;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    alu_sequencer #(.NUM_REGS(NR), .OP_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_ready(Mem_ready), .IR_data(IR_data),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Zin(Zin),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
`ifdef MULDIV_EN
        .LOin(LOin), .HIin(HIin),
`endif
        .Rout(Rout), .Rin(Rin), .operation(operation), .Halted(Halted), .Illegal(Illegal)
    );

`ifndef MULDIV_EN
    assign LOin = 1'b0;
    assign HIin = 1'b0;
`endif

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [NR-1:0] oh(input logic [3:0] f);
        logic [NR-1:0] one;
        one = 1;
        return (int'(f) < NR) ? (one << f) : '0;
    endfunction

    function automatic void put(input int c, input int cut, input logic [15:0] strb,
                                input logic [NR-1:0] ro, input logic [NR-1:0] ri,
                                input logic [4:0] op);
        exp_t e;
        if (c > cut) return;
        e.cyc    = c;
        e.o.strb = strb;
        e.o.rout = ro;
        e.o.rin  = ri;
        e.o.op   = op;
        exp_q.push_back(e);
    endfunction

    // Instruction timeline: s = FETCH0 cycle, w = memory wait cycles, cut = last cycle before reset.
    function automatic int model(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [3:0] rc, input int s, input int w, input int cut);
        int t, last;
        put(s, cut, PCO | MAR | INC | ZI, '0, '0, '0);
        for (int i = 0; i <= w; i++)
            put(s + 1 + i, cut, ZL | RD | MDI | ((i == 0) ? PCI : 16'h0), '0, '0, '0);
        put(s + 2 + w, cut, MDO | IRI, '0, '0, '0);
        t = s + 3 + w;
        if (opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                        5'b01000, 5'b01001, 5'b01010, 5'b01011}) begin
            put(t + 1, cut, YI, oh(rb), '0, '0);
            put(t + 2, cut, ZI, oh(rc), '0, opc);
            put(t + 3, cut, ZL, '0, oh(ra), '0);
            last = t + 3;
        end else if (opc inside {5'b10001, 5'b10010}) begin
            put(t + 1, cut, ZI, oh(rb), '0, opc);
            put(t + 2, cut, ZL, '0, oh(ra), '0);
            last = t + 2;
`ifdef MULDIV_EN
        end else if (opc inside {T_MUL, T_DIV}) begin
            put(t + 1, cut, YI, oh(ra), '0, '0);
            put(t + 2, cut, ZI, oh(rb), '0, opc);
            put(t + 3, cut, ZL | LOI, '0, '0, '0);
            put(t + 4, cut, ZH | HII, '0, '0, '0);
            last = t + 4;
`endif
        end else if (opc == T_NOP) begin
            last = t;
        end else if (opc == T_HALT) begin
            for (int c = t + 1; c <= cut; c++) put(c, cut, HLT, '0, '0, '0);
            last = cut;
        end else begin
            put(t + 1, cut, ILL, '0, '0, '0);
            last = t + 1;
        end
        return (last < cut) ? last : cut;
    endfunction

    always @(negedge Clock) begin
        obs_t a;
        exp_t e;
        if (mon_en) begin
            a.strb = {HIin, LOin, Illegal, Halted, Yin, IRin, MDRout, MDRin, Read,
                      ZHighout, Zlowout, Zin, PCin, IncPC, MARin, PCout};
            a.rout = Rout;
            a.rin  = Rin;
            a.op   = operation;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_cycle cyc=%0d: expected entry never compared, want strb=%h", e.cyc, e.o.strb);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e.o) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d: got strb=%h rout=%h rin=%h op=%h, want strb=%h rout=%h rin=%h op=%h",
                             cyc, a.strb, a.rout, a.rin, a.op, e.o.strb, e.o.rout, e.o.rin, e.o.op);
                end
            end else begin
                checks++;
                if (a !== '0) begin
                    failures++;
                    $display("FAIL idle_zero cyc=%0d: got strb=%h rout=%h rin=%h op=%h, want all 0",
                             cyc, a.strb, a.rout, a.rin, a.op);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            Reset     = 1'b0;
            Run       = 1'b0;
            Mem_ready = 1'($urandom);
            IR_data   = $urandom;
        end
    endtask

    task automatic issue(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input int w, input int rst_off);
        int s, cut, last, roff;
        bit hold_run;
        roff = rst_off;
        if (opc == T_HALT && roff < 0) roff = w + 8;
        hold_run = (opc == T_HALT);
        @(posedge Clock); #1;
        s    = cyc + 1;
        cut  = (roff >= 0) ? s + roff : 32'h7fffffff;
        last = model(opc, ra, rb, rc, s, w, cut);
        IR_data   = {opc, ra, rb, rc, 15'($urandom)};
        Reset     = 1'b0;
        Run       = 1'b1;
        Mem_ready = 1'($urandom);
        while (cyc < last) begin
            @(posedge Clock); #1;
            Reset = (cyc == cut);
            Run   = (cyc == cut) ? 1'b0 : (hold_run ? 1'b1 : 1'($urandom));
            if (cyc >= s + 1 && cyc <= s + w) Mem_ready = 1'b0;
            else if (cyc == s + 1 + w)        Mem_ready = 1'b1;
            else                              Mem_ready = 1'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [4:0] pool [0:14];
        logic [4:0] opc;
        int w, roff;
        pool = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                 5'b01010, 5'b01011, 5'b10001, 5'b10010, T_NOP, T_HALT, T_MUL, T_DIV};
        Reset = 1'b1; Run = 1'b0; Mem_ready = 1'b0; IR_data = '0;
        repeat (3) @(posedge Clock);
        #1;
        Reset  = 1'b0;
        mon_en = 1'b1;
        idle(3);

        issue(T_AND, 4'd4, 4'd5, 4'd7, 0, -1);
        idle(1);
        issue(T_SHL, 4'd9, 4'd1, 4'd14, 3, -1);
        issue(T_NEG, 4'd2, 4'd3, 4'd0, 0, -1);
        idle(2);
        issue(5'b11111, 4'd6, 4'd6, 4'd6, 0, -1);
        idle(2);
        issue(T_HALT, 4'd0, 4'd0, 4'd0, 0, 8);
        idle(2);
        issue(T_AND, 4'd4, 4'd5, 4'd7, 0, 5);
        idle(2);
        issue(T_NOP, 4'd1, 4'd2, 4'd3, 1, -1);
        issue(5'b00011, 4'd3, 4'd3, 4'd3, 0, -1);
        issue(T_MUL, 4'd8, 4'd10, 4'd12, 0, -1);
        idle(1);

        for (int n = 0; n < 80; n++) begin
            opc  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pool[$urandom_range(0, 14)];
            w    = $urandom_range(0, 4);
            roff = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8 + w) : -1;
            issue(opc, 4'($urandom), 4'($urandom), 4'($urandom), w, roff);
            idle($urandom_range(0, 3));
        end

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
